// File: rtl/apb_reg_bank_if.sv
// APB bus bundle between a requester and the apb_reg_bank completer.
// Signal names follow the AMBA APB naming used on the audioport control path.
interface apb_reg_bank_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_bank.sv
// APB completer for a word-aligned window of R/W registers followed by read-only
// status words, with configurable wait states and decode/access error reporting.
module apb_reg_bank #(
  parameter logic [31:0] START_ADDRESS = 32'h8c000000,
  parameter int unsigned NUM_RW        = 136,
  parameter int unsigned NUM_RO        = 4,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  apb_reg_bank_if.slave                                 apb,
  input  logic [(NUM_RO == 0 ? 32 : 32*NUM_RO)-1:0]     ro_in,
  output logic [32*NUM_RW-1:0]                          regs_out,
  output logic [NUM_RW-1:0]                             wr_pulse,
  output logic [NUM_RW+NUM_RO-1:0]                      rd_pulse
);

  localparam int unsigned NUM_REGS  = NUM_RW + NUM_RO;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           cnt;
  logic [3:0]           cnt_next;

  logic [31:0]          index;
  logic                 addr_err;
  logic                 range_err;
  logic                 ro_err;
  logic [31:0]          rd_word;

  logic                 complete_c;
  logic                 err_c;
  logic [31:0]          rdata_c;
  logic                 wr_ok;
  logic                 rd_ok;

  logic [32*NUM_RW-1:0] regs_q;

  // PENABLE carries no information for this completer: PREADY timing is set by the FSM alone.
  logic                 unused_penable;
  assign unused_penable = apb.PENABLE;

  // Offsets below the window wrap to huge indices and fall into the range error.
  assign index     = (apb.PADDR - START_ADDRESS) >> 2;
  assign addr_err  = (apb.PADDR[1:0] != 2'b00);
  assign range_err = (index >= NUM_REGS);
  assign ro_err    = apb.PWRITE && (index >= NUM_RW);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (apb.PSEL) begin
          state_next = ACCESS;
          cnt_next   = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Output logic: completion, error and read data are only non-zero in the PREADY cycle
  always_comb begin
    complete_c = 1'b0;
    err_c      = 1'b0;
    rdata_c    = 32'd0;
    if ((state == ACCESS) && (cnt == 4'd0) && apb.PSEL) begin
      complete_c = 1'b1;
      err_c      = addr_err | range_err | ro_err;
      if (!err_c && !apb.PWRITE) begin
        rdata_c = rd_word;
      end
    end
  end

  assign apb.PREADY  = complete_c;
  assign apb.PSLVERR = err_c;
  assign apb.PRDATA  = rdata_c;

  assign wr_ok = complete_c && apb.PWRITE && !err_c;
  assign rd_ok = complete_c && !apb.PWRITE && !err_c;

  // Read mux over the R/W registers and the read-only status words
  always_comb begin
    rd_word = 32'd0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (index == i) begin
        rd_word = regs_q[32*i +: 32];
      end
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (index == (NUM_RW + k)) begin
        rd_word = ro_in[32*k +: 32];
      end
    end
  end

  // Byte-strobed register update on an error-free write completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if (index == i) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (apb.PSTRB[b]) begin
              regs_q[32*i + 8*b +: 8] <= apb.PWDATA[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Access pulses, one cycle after the completion edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pulse <= '0;
      rd_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        wr_pulse[i] <= wr_ok && (index == i);
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rd_pulse[i] <= rd_ok && (index == i);
      end
    end
  end

  assign regs_out = regs_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: a zero-wait and a three-wait instance share one driven bus,
// checked against directed vectors, corner sequences and a randomized reference model.
module tb_apb_reg_bank;

  localparam logic [31:0] START   = 32'h8c000000;
  localparam int          NRW     = 136;
  localparam int          NRO     = 4;
  localparam int          NREG    = NRW + NRO;
  localparam int          TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared drive; sel routes PSEL to dut0 (0 waits) or dut3 (3 waits)
  logic        sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] ro_words [NRO];
  logic [32*NRO-1:0] ro_bus;

  apb_reg_bank_if bus0 ();
  apb_reg_bank_if bus3 ();

  assign bus0.PSEL    = psel & ~sel;
  assign bus3.PSEL    = psel & sel;
  assign bus0.PENABLE = penable;
  assign bus3.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus3.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus3.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PWDATA  = pwdata;
  assign bus0.PSTRB   = pstrb;
  assign bus3.PSTRB   = pstrb;

  always_comb begin
    for (int k = 0; k < NRO; k++) ro_bus[32*k +: 32] = ro_words[k];
  end

  logic [32*NRW-1:0] regs0, regs3;
  logic [NRW-1:0]    wrp0, wrp3;
  logic [NREG-1:0]   rdp0, rdp3;

  apb_reg_bank #(.START_ADDRESS(START), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .apb(bus0.slave), .ro_in(ro_bus),
    .regs_out(regs0), .wr_pulse(wrp0), .rd_pulse(rdp0));

  apb_reg_bank #(.START_ADDRESS(START), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .apb(bus3.slave), .ro_in(ro_bus),
    .regs_out(regs3), .wr_pulse(wrp3), .rd_pulse(rdp3));

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  assign pready_m  = sel ? bus3.PREADY  : bus0.PREADY;
  assign pslverr_m = sel ? bus3.PSLVERR : bus0.PSLVERR;
  assign prdata_m  = sel ? bus3.PRDATA  : bus0.PRDATA;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: register words per instance, indexed by word offset from START
  logic [31:0] mdl [2][NRW];

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NRW; i++) mdl[s][i] = 32'd0;
  endtask

  task automatic model_xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, output logic e, output logic [31:0] rdv,
                            output int widx, output int ridx);
    logic [31:0] idx;
    idx  = (a - START) >> 2;
    e    = (a[1:0] != 2'b00) || (idx >= 32'(NREG)) || (wr && (idx >= 32'(NRW)));
    rdv  = 32'd0;
    widx = -1;
    ridx = -1;
    if (!e) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
        widx = int'(idx);
      end else begin
        rdv  = (idx < 32'(NRW)) ? mdl[s][idx] : ro_words[idx - 32'(NRW)];
        ridx = int'(idx);
      end
    end
  endtask

  function automatic logic [31:0] word(input int s, input int i);
    return (s != 0) ? regs3[32*i +: 32] : regs0[32*i +: 32];
  endfunction

  function automatic int first_bad(input int s);
    for (int i = 0; i < NRW; i++)
      if (word(s, i) !== mdl[s][i]) return i;
    return 0;
  endfunction

  task automatic check_regs(input string tag, input int s);
    int i;
    i = first_bad(s);
    check($sformatf("%s dut%0d regs_out[%0d]", tag, s * 3, i), word(s, i), mdl[s][i]);
  endtask

  // One APB transfer; returns at the negedge of the PREADY cycle with PSEL still high
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [31:0] rdv, output logic e, output int waits, output logic quiet);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = st;
    quiet = 1'b1;
    #1;
    if (pready_m !== 1'b0 || prdata_m !== 32'd0 || pslverr_m !== 1'b0) quiet = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    waits   = 0;
    while (pready_m !== 1'b1 && waits < TIMEOUT) begin
      if (prdata_m !== 32'd0 || pslverr_m !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      waits++;
    end
    rdv = prdata_m;
    e   = pslverr_m;
  endtask

  // Pulses appear in the cycle after completion and last exactly one cycle
  task automatic post(input string tag, input int s, input int widx, input int ridx);
    logic [NRW-1:0]  ew;
    logic [NREG-1:0] er;
    ew = '0;
    er = '0;
    if (widx >= 0) ew[widx] = 1'b1;
    if (ridx >= 0) er[ridx] = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    check({tag, " wr_pulse"}, (s != 0) ? wrp3 : wrp0, ew);
    check({tag, " rd_pulse"}, (s != 0) ? rdp3 : rdp0, er);
    check_regs(tag, s);
    check_regs(tag, 1 - s);
    @(negedge clk);
    check({tag, " pulses clear"}, {wrp0, wrp3, rdp0, rdp3}, '0);
  endtask

  task automatic run_check(input string tag, input int s, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] st,
                           input logic has_exp, input logic exp_e, input logic [31:0] exp_rd);
    logic        me, e, quiet;
    logic [31:0] mrd, rdv;
    int          widx, ridx, waits;
    sel = (s != 0);
    model_xfer(s, wr, a, d, st, me, mrd, widx, ridx);
    xfer(wr, a, d, st, rdv, e, waits, quiet);
    check({tag, " waits"}, waits, (s != 0) ? 3 : 0);
    check({tag, " quiet before ready"}, quiet, 1'b1);
    check({tag, " pslverr"}, e, me);
    check({tag, " prdata"}, rdv, mrd);
    if (has_exp) begin
      check({tag, " pslverr vector"}, e, exp_e);
      check({tag, " prdata vector"}, rdv, exp_rd);
    end
    post(tag, s, widx, ridx);
  endtask

  typedef struct {
    logic        s;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, quiet;
    logic [31:0] rdv, mrd;
    logic        me;
    int          waits, widx, ridx;

    //          s     wr    addr           wdata          strb     err   rdata
    tbl[0]  = '{1'b0, 1'b0, 32'h8c000000, 32'h0,         4'b0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h8c000010, 32'h11223344,  4'b1111, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h8c000010, 32'hDEADBEEF,  4'b0101, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h8c000010, 32'h0,         4'b0000, 1'b0, 32'h11AD33EF};
    tbl[4]  = '{1'b1, 1'b0, 32'h8c000002, 32'h0,         4'b0000, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h8bfffffc, 32'h12345678,  4'b1111, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'h8c000220, 32'h12345678,  4'b1111, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h8c000220, 32'h0,         4'b0000, 1'b0, 32'hCAFEF00D};
    tbl[8]  = '{1'b1, 1'b0, 32'h8c000230, 32'h0,         4'b0000, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h8c00021c, 32'hFFFFFFFF,  4'b0000, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h8c00021c, 32'h0,         4'b0000, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h8c000000, 32'hAABBCCDD,  4'b1000, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h8c000000, 32'h0,         4'b0000, 1'b0, 32'hAA000000};
    tbl[13] = '{1'b0, 1'b0, 32'h8c00022c, 32'h0,         4'b0000, 1'b0, 32'h0BADF00D};
    tbl[14] = '{1'b0, 1'b0, 32'h8c000013, 32'h0,         4'b0000, 1'b1, 32'h0};

    rst = 1'b1; sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
    ro_words[0] = 32'hCAFEF00D; ro_words[1] = 32'h01234567;
    ro_words[2] = 32'h89ABCDEF; ro_words[3] = 32'h0BADF00D;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset pready", {bus0.PREADY, bus3.PREADY}, 2'b00);
    check("reset pslverr", {bus0.PSLVERR, bus3.PSLVERR}, 2'b00);
    check("reset prdata", {bus0.PRDATA, bus3.PRDATA}, 64'd0);
    check("reset pulses", {wrp0, wrp3, rdp0, rdp3}, '0);
    check_regs("reset", 0);
    check_regs("reset", 1);

    for (int i = 0; i < NVEC; i++)
      run_check($sformatf("vec%0d", i), int'(tbl[i].s), tbl[i].wr, tbl[i].a, tbl[i].d,
                tbl[i].st, 1'b1, tbl[i].e, tbl[i].rd);

    // Abort: PSEL drops in the second wait cycle of a 3-wait write
    sel = 1'b1;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8c000014; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    check("abort wait1 pready", pready_m, 1'b0);
    @(negedge clk);
    check("abort wait2 pready", pready_m, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort idle pready", pready_m, 1'b0);
    check("abort wr_pulse", wrp3, '0);
    @(negedge clk);
    check("abort wr_pulse late", wrp3, '0);
    check_regs("abort", 1);
    run_check("after abort", 1, 1'b1, 32'h8c000014, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0);

    // Back-to-back: setup directly follows the completion cycle
    sel = 1'b1;
    model_xfer(1, 1'b1, 32'h8c000050, 32'h600DCAFE, 4'hF, me, mrd, widx, ridx);
    xfer(1'b1, 32'h8c000050, 32'h600DCAFE, 4'hF, rdv, e, waits, quiet);
    check("b2b first waits", waits, 3);
    model_xfer(1, 1'b0, 32'h8c000050, 32'h0, 4'h0, me, mrd, widx, ridx);
    xfer(1'b0, 32'h8c000050, 32'h0, 4'h0, rdv, e, waits, quiet);
    check("b2b second waits", waits, 3);
    check("b2b second prdata", rdv, 32'h600DCAFE);
    check("b2b second pslverr", e, 1'b0);
    post("b2b", 1, widx, ridx);

    // Reset in the access phase of a write loses the write and clears every register
    run_check("pre-reset write", 1, 1'b1, 32'h8c00001c, 32'h77777777, 4'hF, 1'b0, 1'b0, 32'h0);
    sel = 1'b1;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8c000020; pwdata = 32'h88888888; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    model_clear();
    @(negedge clk);
    check("post-reset pready", pready_m, 1'b0);
    check("post-reset pulses", {wrp0, wrp3, rdp0, rdp3}, '0);
    check_regs("post-reset", 0);
    check_regs("post-reset", 1);
    run_check("post-reset read", 1, 1'b0, 32'h8c000020, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      int          s, cat;
      logic        wr;
      logic [31:0] a;
      s   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      cat = int'($urandom_range(0, 9));
      if (cat <= 5)      a = START + 32'(4 * $urandom_range(0, NRW - 1));
      else if (cat == 6) a = START + 32'(4 * $urandom_range(NRW, NREG - 1));
      else if (cat == 7) a = START + 32'(4 * $urandom_range(NREG, NREG + 50));
      else if (cat == 8) a = START + 32'(4 * $urandom_range(0, NREG - 1)) + 32'($urandom_range(1, 3));
      else               a = START - 32'(4 * $urandom_range(1, 64));
      ro_words[$urandom_range(0, NRO - 1)] = $urandom;
      run_check($sformatf("rand%0d", n), s, wr, a, $urandom, 4'($urandom_range(0, 15)),
                1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
